iic_test: RTL and testbench

I2C (IIC) master for a 24Cxx-style serial EEPROM, clocked from the 100 MHz system clock. A one-cycle start strobe with a 32-bit configuration word launches one transaction on the bus:
- a single-byte write, or
- a single-byte random read, whose result appears on `o_rd_dat`.

The block sits between local configuration/control logic and the board-level SCL/SDA pins.

---
 rtl/iic_test.sv | 177 +++++++++++++++++
 tb/tb_iic_test.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/iic_test.sv
// Single-byte write / random-read I2C master for 24Cxx EEPROMs; one bit = 4 quarter phases of SYS_CLK_HZ/SCL_HZ/4 cycles.
// Optional macro IIC_ACK_CHECK_EN aborts to STOP on a slave NACK; otherwise ACK bits are clocked and ignored.
module iic_test #(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int SCL_HZ     = 100_000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [31:0] i_cfg_dat,
    input  logic        i_cfg_start_en,
    output logic        iic_scl,
    inout  wire         iic_sda,
    output logic [7:0]  o_rd_dat,
    output logic        o_busy
);

    localparam int BIT_CYC = SYS_CLK_HZ / SCL_HZ;
    localparam int Q_CYC   = BIT_CYC / 4;
    localparam int CW      = $clog2(BIT_CYC);
    localparam logic [CW-1:0] C_Q1  = CW'(Q_CYC);
    localparam logic [CW-1:0] C_Q2  = CW'(2 * Q_CYC);
    localparam logic [CW-1:0] C_Q3  = CW'(3 * Q_CYC);
    localparam logic [CW-1:0] C_END = CW'(BIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEND, S_SACK, S_RESTART, S_READ, S_MNACK, S_STOP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte, w_byte_nxt;
    logic [7:0]    r_sh, w_tx_byte;
    logic [6:0]    r_dev;
    logic [7:0]    r_word, r_wdat, r_rd_dat;
    logic          r_rd, r_scl, r_sda_low;
    logic          w_scl, w_sda_low, w_bit_end, w_sample, w_nack, w_sda_in;
    logic          w_unused;

    assign w_unused  = i_cfg_dat[24];
    assign w_bit_end = (r_cnt == C_END);
    assign w_sample  = (r_cnt == C_Q3);
    assign w_sda_in  = iic_sda;

    assign iic_scl  = r_scl;
    assign iic_sda  = r_sda_low ? 1'b0 : 1'bz;
    assign o_rd_dat = r_rd_dat;
    assign o_busy   = (r_state != S_IDLE);

`ifdef IIC_ACK_CHECK_EN
    logic r_nack;
    // Anything other than a clean low (released, Z or X) is a NACK.
    always_ff @(posedge sys_clk) begin
        if (rst_n || r_state == S_IDLE) begin
            r_nack <= 1'b0;
        end else if (r_state == S_SACK && w_sample) begin
            if (iic_sda == 1'b0) r_nack <= 1'b0;
            else                 r_nack <= 1'b1;
        end
    end
    assign w_nack = r_nack;
`else
    assign w_nack = 1'b0;
`endif

    always_comb begin
        w_tx_byte = r_wdat;
        case (w_byte_nxt)
            2'd0:    w_tx_byte = {r_dev, 1'b0};
            2'd1:    w_tx_byte = r_word;
            default: w_tx_byte = r_rd ? {r_dev, 1'b1} : r_wdat;
        endcase
    end

    // SDA only moves while SCL is low; in Q0 of a data bit it holds its previous level.
    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte;
        w_scl       = (r_cnt >= C_Q2);
        w_sda_low   = r_sda_low;
        case (r_state)
            S_IDLE: begin
                w_scl      = 1'b1;
                w_sda_low  = 1'b0;
                w_byte_nxt = 2'd0;
                if (i_cfg_start_en) w_state_nxt = S_START;
            end
            S_START: begin
                w_scl     = 1'b1;
                w_sda_low = (r_cnt >= C_Q2);
                if (w_bit_end) w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (r_cnt >= C_Q1) w_sda_low = ~r_sh[7];
                if (w_bit_end && r_bit == 3'd7) w_state_nxt = S_SACK;
            end
            S_SACK: begin
                if (r_cnt >= C_Q1) w_sda_low = 1'b0;
                if (w_bit_end) begin
                    w_byte_nxt = r_byte + 2'd1;
                    if (w_nack) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        case (r_byte)
                            2'd0:    w_state_nxt = S_SEND;
                            2'd1:    w_state_nxt = r_rd ? S_RESTART : S_SEND;
                            default: w_state_nxt = r_rd ? S_READ : S_STOP;
                        endcase
                    end
                end
            end
            S_RESTART: begin
                w_sda_low = 1'b0;
                if (w_bit_end) w_state_nxt = S_START;
            end
            S_READ: begin
                if (r_cnt >= C_Q1) w_sda_low = 1'b0;
                if (w_bit_end && r_bit == 3'd7) w_state_nxt = S_MNACK;
            end
            S_MNACK: begin
                if (r_cnt >= C_Q1) w_sda_low = 1'b0;
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                w_scl     = (r_cnt >= C_Q1);
                w_sda_low = (r_cnt < C_Q2);
                if (w_bit_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_sh      <= '0;
            r_dev     <= '0;
            r_word    <= '0;
            r_wdat    <= '0;
            r_rd      <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_low <= 1'b0;
            r_rd_dat  <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_scl     <= w_scl;
            r_sda_low <= w_sda_low;
            r_byte    <= w_byte_nxt;
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
                r_bit <= '0;
                if (i_cfg_start_en) begin
                    r_dev  <= i_cfg_dat[31:25];
                    r_word <= i_cfg_dat[23:16];
                    r_wdat <= i_cfg_dat[7:0];
                    r_rd   <= (i_cfg_dat[15:8] == 8'h00);
                end
            end else begin
                r_cnt <= w_bit_end ? '0 : r_cnt + CW'(1);
                if (w_bit_end && (r_state == S_SEND || r_state == S_READ))
                    r_bit <= r_bit + 3'd1;
            end
            if (w_state_nxt == S_SEND && r_state != S_SEND) begin
                r_sh <= w_tx_byte;
            end else if (r_state == S_SEND && w_bit_end) begin
                r_sh <= {r_sh[6:0], 1'b0};
            end else if (r_state == S_READ && w_sample) begin
                r_sh <= {r_sh[6:0], w_sda_in};
                if (r_bit == 3'd7) r_rd_dat <= {r_sh[6:0], w_sda_in};
            end
        end
    end

endmodule

// File: tb/tb_iic_test.sv
// Directed bench for iic_test: bus monitor plus EEPROM slave model; DUT run at a 100-cycle bit time.
// Frame lengths are scaled from the 1000-cycle default (write 29 bits, read 40 bits).
module tb_iic_test;

    localparam int SYS_HZ = 10_000_000;
    localparam int SCL_HZ = 100_000;
    localparam int BIT    = SYS_HZ / SCL_HZ;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_cfg_dat;
    logic        i_cfg_start_en;
    logic        iic_scl;
    wire         iic_sda;
    logic [7:0]  o_rd_dat;
    logic        o_busy;

    logic        slv_low = 1'b0;
    logic        slv_en;
    logic        mon_clr = 1'b1;
    logic [7:0]  slv_dat = 8'h5A;

    int          n_chk = 0;
    int          n_err = 0;

    int          n_start, n_stop, n_byte, bcnt, bif, busy_cnt;
    logic [7:0]  rec_b [8];
    logic        rec_a [8];
    logic [8:0]  sh;
    logic        rd_mode;
    logic        p_scl = 1'b1;
    logic        p_sda = 1'b1;

    assign iic_sda = slv_low ? 1'b0 : 1'bz;
    pullup (iic_sda);

    always #5 sys_clk = ~sys_clk;

    iic_test #(.SYS_CLK_HZ(SYS_HZ), .SCL_HZ(SCL_HZ)) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .i_cfg_dat      (i_cfg_dat),
        .i_cfg_start_en (i_cfg_start_en),
        .iic_scl        (iic_scl),
        .iic_sda        (iic_sda),
        .o_rd_dat       (o_rd_dat),
        .o_busy         (o_busy)
    );

    // Bus monitor and slave: acks written bytes, returns slv_dat after an address byte with R=1.
    always @(negedge sys_clk) begin
        if (mon_clr) begin
            n_start = 0; n_stop = 0; n_byte = 0; bcnt = 0; bif = 0; busy_cnt = 0;
            sh = '0; rd_mode = 1'b0; slv_low = 1'b0;
        end else begin
            if (o_busy) busy_cnt++;
            if (p_scl && iic_scl && p_sda && !iic_sda) begin
                n_start++; bcnt = 0; bif = 0; rd_mode = 1'b0; slv_low = 1'b0;
            end else if (p_scl && iic_scl && !p_sda && iic_sda) begin
                n_stop++; bcnt = 0; rd_mode = 1'b0; slv_low = 1'b0;
            end else if (!p_scl && iic_scl) begin
                sh = {sh[7:0], iic_sda};
                bcnt++;
            end else if (p_scl && !iic_scl) begin
                if (bcnt == 9) begin
                    if (n_byte < 8) begin
                        rec_b[n_byte] = sh[8:1];
                        rec_a[n_byte] = sh[0];
                    end
                    n_byte++;
                    slv_low = 1'b0;
                    if (rd_mode) begin
                        rd_mode = 1'b0;
                    end else if (slv_en && bif == 0 && sh[1]) begin
                        rd_mode = 1'b1;
                        slv_low = !slv_dat[7];
                    end
                    bif++;
                    bcnt = 0;
                end else if (bcnt == 8) begin
                    slv_low = slv_en && !rd_mode;
                end else if (rd_mode && bcnt >= 1 && bcnt <= 7) begin
                    slv_low = !slv_dat[3'(7 - bcnt)];
                end
            end
        end
        p_scl = iic_scl;
        p_sda = iic_sda;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge sys_clk); mon_clr = 1'b1;
        @(posedge sys_clk); mon_clr = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] cfg);
        @(negedge sys_clk);
        i_cfg_dat      = cfg;
        i_cfg_start_en = 1'b1;
        @(negedge sys_clk);
        i_cfg_start_en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 * BIT && o_busy; i++) @(negedge sys_clk);
        check("idle_timeout", {31'd0, o_busy}, 32'd0);
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic check_byte(input string tag, input int idx, input logic [7:0] b, input logic a);
        check($sformatf("%s_byte%0d", tag, idx), {24'd0, rec_b[idx]}, {24'd0, b});
        check($sformatf("%s_ack%0d", tag, idx), {31'd0, rec_a[idx]}, {31'd0, a});
    endtask

    initial begin
        rst_n = 1'b1; i_cfg_dat = '0; i_cfg_start_en = 1'b0; slv_en = 1'b1;
        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk) rst_n = 1'b0;
        @(negedge sys_clk);
        check("rst_scl",  {31'd0, iic_scl}, 32'd1);
        check("rst_sda",  {31'd0, iic_sda}, 32'd1);
        check("rst_rd",   {24'd0, o_rd_dat}, 32'h00);
        check("rst_busy", {31'd0, o_busy}, 32'd0);

        // Byte write: AE, E6, E1
        clr_mon();
        strobe(32'hAEE6ADE1);
        wait_idle();
        check("wr_start", n_start, 1);
        check("wr_stop",  n_stop, 1);
        check("wr_nbyte", n_byte, 3);
        check_byte("wr", 0, 8'hAE, 1'b0);
        check_byte("wr", 1, 8'hE6, 1'b0);
        check_byte("wr", 2, 8'hE1, 1'b0);
        check("wr_busy", busy_cnt, 29 * BIT);
        check("wr_rd",   {24'd0, o_rd_dat}, 32'h00);

        // Random read: AE, E6, restart, AF, 5A + master NACK
        clr_mon();
        strobe(32'hAEE600A5);
        wait_idle();
        check("rd_start", n_start, 2);
        check("rd_stop",  n_stop, 1);
        check("rd_nbyte", n_byte, 4);
        check_byte("rd", 0, 8'hAE, 1'b0);
        check_byte("rd", 1, 8'hE6, 1'b0);
        check_byte("rd", 2, 8'hAF, 1'b0);
        check_byte("rd", 3, 8'h5A, 1'b1);
        check("rd_busy", busy_cnt, 40 * BIT);
        check("rd_dat",  {24'd0, o_rd_dat}, 32'h5A);

        // Strobe while busy is ignored
        clr_mon();
        strobe(32'hAEE6ADE1);
        repeat (3 * BIT - 1) @(negedge sys_clk);
        strobe(32'hA0110000);
        wait_idle();
        check("bz_start", n_start, 1);
        check("bz_nbyte", n_byte, 3);
        check_byte("bz", 0, 8'hAE, 1'b0);
        check_byte("bz", 1, 8'hE6, 1'b0);
        check_byte("bz", 2, 8'hE1, 1'b0);
        check("bz_busy", busy_cnt, 29 * BIT);
        check("bz_rd",   {24'd0, o_rd_dat}, 32'h5A);

        // No slave: SDA only pulled up
        slv_en = 1'b0;
        clr_mon();
        strobe(32'hAEE6ADE1);
        wait_idle();
        check("ns_stop", n_stop, 1);
        check_byte("ns", 0, 8'hAE, 1'b1);
`ifdef IIC_ACK_CHECK_EN
        check("ns_nbyte", n_byte, 1);
        check("ns_busy",  busy_cnt, 11 * BIT);
`else
        check("ns_nbyte", n_byte, 3);
        check_byte("ns", 1, 8'hE6, 1'b1);
        check_byte("ns", 2, 8'hE1, 1'b1);
        check("ns_busy",  busy_cnt, 29 * BIT);
`endif
        check("ns_rd", {24'd0, o_rd_dat}, 32'h5A);
        slv_en = 1'b1;

        // Reset in the middle of a write
        clr_mon();
        strobe(32'hAEE6ADE1);
        repeat (15 * BIT) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("mr_scl",  {31'd0, iic_scl}, 32'd1);
        check("mr_sda",  {31'd0, iic_sda}, 32'd1);
        check("mr_busy", {31'd0, o_busy}, 32'd0);
        check("mr_rd",   {24'd0, o_rd_dat}, 32'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        clr_mon();
        strobe(32'hAEE600A5);
        wait_idle();
        check("mr2_nbyte", n_byte, 4);
        check_byte("mr2", 2, 8'hAF, 1'b0);
        check("mr2_busy", busy_cnt, 40 * BIT);
        check("mr2_rd",   {24'd0, o_rd_dat}, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
